// File: rtl/csc_yuv2rgb.sv
// csc_yuv2rgb: 3-stage pipelined YUV->RGB converter with Q16 coefficients.
// Ports: Clock, Reset (async, active high); in_valid/in_ready + Y_in/U_in/V_in
// in; out_valid/out_ready + R_out/G_out/B_out out. Optional CSC_CLIP_COUNT_EN
// adds clip_count_clr (in) and clip_count (out, saturating clip counter).

module csc_mul32 (
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic signed [31:0] p
);
  // 32x32 signed multiply, low word kept
  assign p = a * b;
endmodule

module csc_yuv2rgb #(
  parameter int COEF_Y    = 76284,
  parameter int COEF_RV   = 104595,
  parameter int COEF_GU   = 25624,
  parameter int COEF_GV   = 53281,
  parameter int COEF_BU   = 132251,
  parameter int FRAC_BITS = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  Y_in,
  input  logic [7:0]  U_in,
  input  logic [7:0]  V_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  R_out,
  output logic [7:0]  G_out,
  output logic [7:0]  B_out
`ifdef CSC_CLIP_COUNT_EN
  ,
  input  logic        clip_count_clr,
  output logic [15:0] clip_count
`endif
);

  localparam logic signed [31:0] K_Y  = 32'(COEF_Y);
  localparam logic signed [31:0] K_RV = 32'(COEF_RV);
  localparam logic signed [31:0] K_GU = 32'(COEF_GU);
  localparam logic signed [31:0] K_GV = 32'(COEF_GV);
  localparam logic signed [31:0] K_BU = 32'(COEF_BU);

  function automatic logic [7:0] clip8(
    input logic signed [31:0] s
  );
    if (s < 0)
      return 8'd0;
    else if (s > 255)
      return 8'd255;
    else
      return s[7:0];
  endfunction

  // whole pipeline moves in lockstep;
  // a stalled output freezes every stage
  logic advance;
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  // S1: offset-removed components
  logic              s1_vld;
  logic signed [8:0] s1_y;
  logic signed [8:0] s1_u;
  logic signed [8:0] s1_v;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_vld <= 1'b0;
      s1_y   <= '0;
      s1_u   <= '0;
      s1_v   <= '0;
    end else if (advance) begin
      s1_vld <= in_valid;
      s1_y   <= $signed({1'b0, Y_in}) - 9'sd16;
      s1_u   <= $signed({1'b0, U_in}) - 9'sd128;
      s1_v   <= $signed({1'b0, V_in}) - 9'sd128;
    end
  end

  logic signed [31:0] m_y;
  logic signed [31:0] m_u;
  logic signed [31:0] m_v;

  assign m_y = {{23{s1_y[8]}}, s1_y};
  assign m_u = {{23{s1_u[8]}}, s1_u};
  assign m_v = {{23{s1_v[8]}}, s1_v};

  logic signed [31:0] p_y;
  logic signed [31:0] p_rv;
  logic signed [31:0] p_gu;
  logic signed [31:0] p_gv;
  logic signed [31:0] p_bu;

  csc_mul32 u_mul_y (
    .a(K_Y), .b(m_y), .p(p_y)
  );
  csc_mul32 u_mul_rv (
    .a(K_RV), .b(m_v), .p(p_rv)
  );
  csc_mul32 u_mul_gu (
    .a(K_GU), .b(m_u), .p(p_gu)
  );
  csc_mul32 u_mul_gv (
    .a(K_GV), .b(m_v), .p(p_gv)
  );
  csc_mul32 u_mul_bu (
    .a(K_BU), .b(m_u), .p(p_bu)
  );

  // S2: registered products
  logic               s2_vld;
  logic signed [31:0] s2_py;
  logic signed [31:0] s2_prv;
  logic signed [31:0] s2_pgu;
  logic signed [31:0] s2_pgv;
  logic signed [31:0] s2_pbu;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s2_vld <= 1'b0;
      s2_py  <= '0;
      s2_prv <= '0;
      s2_pgu <= '0;
      s2_pgv <= '0;
      s2_pbu <= '0;
    end else if (advance) begin
      s2_vld <= s1_vld;
      s2_py  <= p_y;
      s2_prv <= p_rv;
      s2_pgu <= p_gu;
      s2_pgv <= p_gv;
      s2_pbu <= p_bu;
    end
  end

  // sums and arithmetic (floor) shift
  logic signed [31:0] r_sum;
  logic signed [31:0] g_sum;
  logic signed [31:0] b_sum;
  logic signed [31:0] r_sh;
  logic signed [31:0] g_sh;
  logic signed [31:0] b_sh;

  assign r_sum = s2_py + s2_prv;
  assign g_sum = s2_py - s2_pgu - s2_pgv;
  assign b_sum = s2_py + s2_pbu;

  assign r_sh = r_sum >>> FRAC_BITS;
  assign g_sh = g_sum >>> FRAC_BITS;
  assign b_sh = b_sum >>> FRAC_BITS;

  // S3: output register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out_valid <= 1'b0;
      R_out     <= '0;
      G_out     <= '0;
      B_out     <= '0;
    end else if (advance) begin
      out_valid <= s2_vld;
      R_out     <= clip8(r_sh);
      G_out     <= clip8(g_sh);
      B_out     <= clip8(b_sh);
    end
  end

`ifdef CSC_CLIP_COUNT_EN
  logic        c_r;
  logic        c_g;
  logic        c_b;
  logic [1:0]  n_clip;
  logic [16:0] cnt_sum;

  assign c_r = (r_sh < 0) || (r_sh > 255);
  assign c_g = (g_sh < 0) || (g_sh > 255);
  assign c_b = (b_sh < 0) || (b_sh > 255);

  assign n_clip  = 2'(c_r) + 2'(c_g) + 2'(c_b);
  assign cnt_sum = {1'b0, clip_count} + {15'd0, n_clip};

  // counted as the pixel enters S3; clear beats increment
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      clip_count <= '0;
    else if (clip_count_clr)
      clip_count <= '0;
    else if (advance && s2_vld)
      clip_count <= cnt_sum[16] ? 16'hFFFF
                                : cnt_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_csc_yuv2rgb.sv
// tb_csc_yuv2rgb: scoreboard bench for csc_yuv2rgb.
// Real-arithmetic reference model; directed, backpressure, reset, random.
`timescale 1ns/1ps

module tb_csc_yuv2rgb;

  logic        Clock     = 1'b0;
  logic        Reset     = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [7:0]  Y_in      = '0;
  logic [7:0]  U_in      = '0;
  logic [7:0]  V_in      = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  R_out;
  logic [7:0]  G_out;
  logic [7:0]  B_out;
`ifdef CSC_CLIP_COUNT_EN
  logic        clip_count_clr = 1'b0;
  logic [15:0] clip_count;
`endif

  csc_yuv2rgb dut (
    .Clock(Clock),
    .Reset(Reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .Y_in(Y_in),
    .U_in(U_in),
    .V_in(V_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .R_out(R_out),
    .G_out(G_out),
    .B_out(B_out)
`ifdef CSC_CLIP_COUNT_EN
    ,
    .clip_count_clr(clip_count_clr),
    .clip_count(clip_count)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } px_t;

  px_t exp_q[$];
  int  n_chk    = 0;
  int  n_fail   = 0;
  int  n_out    = 0;
  int  clip_exp = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               nm, got, got, want, want, $time);
    end
  endtask

  // Reference: real-valued conversion, floor, clamp to 0..255
  function automatic px_t ref_px(input logic [7:0] y8,
                                 input logic [7:0] u8,
                                 input logic [7:0] v8,
                                 output int nclip);
    real  y, u, v, py;
    real  s[3];
    int   c;
    logic [7:0] o[3];
    px_t  p;
    y  = real'(int'(y8)) - 16.0;
    u  = real'(int'(u8)) - 128.0;
    v  = real'(int'(v8)) - 128.0;
    py = 76284.0 * y;
    s[0] = py + 104595.0 * v;
    s[1] = py - 25624.0 * u - 53281.0 * v;
    s[2] = py + 132251.0 * u;
    nclip = 0;
    for (int i = 0; i < 3; i++) begin
      c = int'($floor(s[i] / 65536.0));
      if (c < 0) begin
        o[i] = 8'd0;
        nclip++;
      end else if (c > 255) begin
        o[i] = 8'd255;
        nclip++;
      end else begin
        o[i] = 8'(c);
      end
    end
    p.r = o[0];
    p.g = o[1];
    p.b = o[2];
    return p;
  endfunction

  // One cycle of stimulus; records an accepted triplet in the scoreboard
  task automatic drive(input bit iv,
                       input logic [7:0] y,
                       input logic [7:0] u,
                       input logic [7:0] v,
                       input bit ordy,
                       output bit acc);
    int  nc;
    px_t e;
    @(negedge Clock);
    in_valid  = iv;
    Y_in      = y;
    U_in      = u;
    V_in      = v;
    out_ready = ordy;
    #1;
    acc = iv && in_ready;
    if (acc) begin
      e = ref_px(y, u, v, nc);
      exp_q.push_back(e);
      clip_exp += nc;
    end
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    drive(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), ordy, acc);
  endtask

  // Single pixel into an empty pipe: latency, value, clip delta
  task automatic lat_test(input logic [7:0] y,
                          input logic [7:0] u,
                          input logic [7:0] v,
                          input px_t want,
                          input int dclip);
    bit acc;
    int n;
    int c0;
    c0 = 0;
`ifdef CSC_CLIP_COUNT_EN
    c0 = int'(clip_count);
`endif
    drive(1'b1, y, u, v, 1'b1, acc);
    chk("lat_accept", acc, 1);
    n = 0;
    while (n < 10) begin
      idle(1'b1);
      n++;
      if (out_valid) break;
    end
    chk("latency", n, 3);
    chk("lat_px", {R_out, G_out, B_out}, want);
`ifdef CSC_CLIP_COUNT_EN
    chk("clip_delta", int'(clip_count) - c0, dclip);
`else
    if (dclip < 0 || c0 != 0) $display("note: unexpected clip arg");
`endif
  endtask

  // Monitor: pops scoreboard on each output transfer, checks stall hold
  initial begin
    px_t        e;
    logic       held;
    logic [23:0] prev;
    held = 1'b0;
    prev = '0;
    forever begin
      @(negedge Clock);
      #2;
      if (Reset) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", {R_out, G_out, B_out}, prev);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pixel: got %0h expected none",
                   {R_out, G_out, B_out});
        end else begin
          e = exp_q.pop_front();
          chk("R", R_out, e.r);
          chk("G", G_out, e.g);
          chk("B", B_out, e.b);
          n_out++;
        end
      end
      held = out_valid && !out_ready;
      prev = {R_out, G_out, B_out};
    end
  end

  initial begin
    bit         acc;
    int         idx;
    int         j;
    int         o0;
    int         nc;
    px_t        w;
    logic [7:0] ry, ru, rv;
    logic [7:0] bp[6][3];

    repeat (3) @(negedge Clock);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rgb", {R_out, G_out, B_out}, 0);
`ifdef CSC_CLIP_COUNT_EN
    chk("rst_clip_count", clip_count, 0);
`endif
    @(negedge Clock);
    Reset = 1'b0;

    lat_test(8'd16,  8'd128, 8'd128, 24'h000000, 0);
    lat_test(8'd235, 8'd128, 8'd128,
             {8'd254, 8'd254, 8'd254}, 0);
    lat_test(8'd255, 8'd128, 8'd128, 24'hFFFFFF, 3);
    lat_test(8'd0,   8'd128, 8'd128, 24'h000000, 3);
    lat_test(8'd81,  8'd90,  8'd240,
             {8'd254, 8'd0, 8'd0}, 2);
    idle(1'b1);
    idle(1'b1);

    // Backpressure: six triplets, consumer stalled
    for (int i = 0; i < 6; i++) begin
      bp[i][0] = 8'(16 + 30 * i);
      bp[i][1] = 8'($urandom);
      bp[i][2] = 8'($urandom);
    end
    idx = 0;
    o0  = n_out;
    for (int c = 0; c < 8; c++) begin
      j = (idx < 6) ? idx : 5;
      drive(1'b1, bp[j][0], bp[j][1], bp[j][2], 1'b0, acc);
      if (acc) idx++;
      if (out_valid) chk("bp_in_ready", in_ready, 0);
    end
    chk("bp_accepted", idx, 3);
    chk("bp_out_valid", out_valid, 1);
    for (int c = 0; c < 40; c++) begin
      if (idx >= 6 && exp_q.size() == 0) break;
      j = (idx < 6) ? idx : 5;
      drive(idx < 6, bp[j][0], bp[j][1], bp[j][2], 1'b1, acc);
      if (acc) idx++;
    end
    idle(1'b1);
    chk("bp_sent", idx, 6);
    chk("bp_out_count", n_out - o0, 6);

    // Reset in the middle of a stream
    for (int c = 0; c < 10; c++)
      drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom),
            1'b1, acc);
    @(negedge Clock);
    Reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_rgb", {R_out, G_out, B_out}, 0);
    chk("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    ry = 8'($urandom);
    ru = 8'($urandom);
    rv = 8'($urandom);
    w  = ref_px(ry, ru, rv, nc);
    lat_test(ry, ru, rv, w, nc);
    idle(1'b1);
    idle(1'b1);

`ifdef CSC_CLIP_COUNT_EN
    @(negedge Clock);
    clip_count_clr = 1'b1;
    @(negedge Clock);
    clip_count_clr = 1'b0;
    #1;
    chk("clip_clear", clip_count, 0);
`endif
    clip_exp = 0;

    // Randomised traffic with random backpressure
    for (int c = 0; c < 400; c++)
      drive($urandom_range(0, 9) < 7,
            8'($urandom), 8'($urandom), 8'($urandom),
            $urandom_range(0, 9) < 7, acc);
    for (int c = 0; c < 20; c++)
      idle(1'b1);
    chk("drain_empty", exp_q.size(), 0);
`ifdef CSC_CLIP_COUNT_EN
    chk("clip_total", clip_count, clip_exp);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
